// File: rtl/komandara_axi4lite_slave.sv
// AXI4-Lite slave that turns each AXI transaction into one request on a local req/rsp port.
// AW, W and AR are buffered independently; accesses outside the window are answered with DECERR.
module komandara_axi4lite_slave #(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32,
  parameter int MEM_BYTES  = 4096,
  localparam int STRB_WIDTH = DATA_WIDTH / 8
) (
  input  logic                  clk_i,
  input  logic                  rst_ni,
  input  logic [ADDR_WIDTH-1:0] s_axi_awaddr_i,
  input  logic [2:0]            s_axi_awprot_i,
  input  logic                  s_axi_awvalid_i,
  output logic                  s_axi_awready_o,
  input  logic [DATA_WIDTH-1:0] s_axi_wdata_i,
  input  logic [STRB_WIDTH-1:0] s_axi_wstrb_i,
  input  logic                  s_axi_wvalid_i,
  output logic                  s_axi_wready_o,
  output logic [1:0]            s_axi_bresp_o,
  output logic                  s_axi_bvalid_o,
  input  logic                  s_axi_bready_i,
  input  logic [ADDR_WIDTH-1:0] s_axi_araddr_i,
  input  logic [2:0]            s_axi_arprot_i,
  input  logic                  s_axi_arvalid_i,
  output logic                  s_axi_arready_o,
  output logic [DATA_WIDTH-1:0] s_axi_rdata_o,
  output logic [1:0]            s_axi_rresp_o,
  output logic                  s_axi_rvalid_o,
  input  logic                  s_axi_rready_i,
  output logic                  req_valid_o,
  input  logic                  req_ready_i,
  output logic                  req_write_o,
  output logic [ADDR_WIDTH-1:0] req_addr_o,
  output logic [DATA_WIDTH-1:0] req_wdata_o,
  output logic [STRB_WIDTH-1:0] req_wstrb_o,
  input  logic                  rsp_valid_i,
  input  logic [DATA_WIDTH-1:0] rsp_rdata_i,
  input  logic                  rsp_err_i
);
  typedef enum logic [2:0] {IDLE, WR_REQ, WR_WAIT, WR_RESP, RD_REQ, RD_WAIT, RD_RESP} state_e;

  localparam logic [ADDR_WIDTH-1:0] MEM_LIMIT = ADDR_WIDTH'(MEM_BYTES);
  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;
  localparam logic [1:0] RESP_DECERR = 2'b11;

  state_e                state_reg, state_next;
  logic                  aw_full_reg, aw_full_next, w_full_reg, w_full_next, ar_full_reg, ar_full_next;
  logic [ADDR_WIDTH-1:0] awaddr_reg, awaddr_next, araddr_reg, araddr_next;
  logic [DATA_WIDTH-1:0] wdata_reg, wdata_next;
  logic [STRB_WIDTH-1:0] wstrb_reg, wstrb_next;
  logic                  awready_reg, wready_reg, arready_reg;
  logic                  prefer_wr_reg, prefer_wr_next;
  logic                  req_write_reg, req_write_next;
  logic [ADDR_WIDTH-1:0] req_addr_reg, req_addr_next;
  logic [DATA_WIDTH-1:0] req_wdata_reg, req_wdata_next;
  logic [STRB_WIDTH-1:0] req_wstrb_reg, req_wstrb_next;
  logic [1:0]            resp_reg, resp_next;
  logic [DATA_WIDTH-1:0] rdata_reg, rdata_next;

  logic                  aw_hs, w_hs, ar_hs, wr_pend, rd_pend, start_wr, start_rd;
  logic [ADDR_WIDTH-1:0] wr_addr, rd_addr;
  logic [DATA_WIDTH-1:0] wr_data;
  logic [STRB_WIDTH-1:0] wr_strb;
  logic                  unused_prot;

  assign unused_prot = ^{s_axi_awprot_i, s_axi_arprot_i};

  assign aw_hs = s_axi_awvalid_i & awready_reg;
  assign w_hs  = s_axi_wvalid_i & wready_reg;
  assign ar_hs = s_axi_arvalid_i & arready_reg;

  // A beat handshaking this cycle counts as pending, so IDLE can start without a bubble.
  assign wr_pend = (aw_full_reg | aw_hs) & (w_full_reg | w_hs);
  assign rd_pend = ar_full_reg | ar_hs;
  assign wr_addr = aw_full_reg ? awaddr_reg : s_axi_awaddr_i;
  assign wr_data = w_full_reg ? wdata_reg : s_axi_wdata_i;
  assign wr_strb = w_full_reg ? wstrb_reg : s_axi_wstrb_i;
  assign rd_addr = ar_full_reg ? araddr_reg : s_axi_araddr_i;

  assign start_wr = (state_reg == IDLE) & wr_pend & (~rd_pend | prefer_wr_reg);
  assign start_rd = (state_reg == IDLE) & rd_pend & ~start_wr;

  always_comb begin
    aw_full_next = aw_full_reg;
    w_full_next  = w_full_reg;
    ar_full_next = ar_full_reg;
    awaddr_next  = awaddr_reg;
    wdata_next   = wdata_reg;
    wstrb_next   = wstrb_reg;
    araddr_next  = araddr_reg;
    if (aw_hs) begin
      aw_full_next = 1'b1;
      awaddr_next  = s_axi_awaddr_i;
    end
    if (w_hs) begin
      w_full_next = 1'b1;
      wdata_next  = s_axi_wdata_i;
      wstrb_next  = s_axi_wstrb_i;
    end
    if (ar_hs) begin
      ar_full_next = 1'b1;
      araddr_next  = s_axi_araddr_i;
    end
    if (start_wr) begin
      aw_full_next = 1'b0;
      w_full_next  = 1'b0;
    end
    if (start_rd) ar_full_next = 1'b0;
  end

  always_comb begin
    state_next     = state_reg;
    prefer_wr_next = prefer_wr_reg;
    req_write_next = req_write_reg;
    req_addr_next  = req_addr_reg;
    req_wdata_next = req_wdata_reg;
    req_wstrb_next = req_wstrb_reg;
    resp_next      = resp_reg;
    rdata_next     = rdata_reg;
    case (state_reg)
      IDLE: begin
        if (start_wr) begin
          prefer_wr_next = 1'b0;
          req_write_next = 1'b1;
          req_addr_next  = {wr_addr[ADDR_WIDTH-1:2], 2'b00};
          req_wdata_next = wr_data;
          req_wstrb_next = wr_strb;
          if (wr_addr < MEM_LIMIT) begin
            state_next = WR_REQ;
          end else begin
            state_next = WR_RESP;
            resp_next  = RESP_DECERR;
          end
        end else if (start_rd) begin
          prefer_wr_next = 1'b1;
          req_write_next = 1'b0;
          req_addr_next  = {rd_addr[ADDR_WIDTH-1:2], 2'b00};
          req_wdata_next = '0;
          req_wstrb_next = '0;
          rdata_next     = '0;
          if (rd_addr < MEM_LIMIT) begin
            state_next = RD_REQ;
          end else begin
            state_next = RD_RESP;
            resp_next  = RESP_DECERR;
          end
        end
      end
      WR_REQ:  if (req_ready_i) state_next = WR_WAIT;
      WR_WAIT: if (rsp_valid_i) begin
        resp_next  = rsp_err_i ? RESP_SLVERR : RESP_OKAY;
        state_next = WR_RESP;
      end
      WR_RESP: if (s_axi_bready_i) state_next = IDLE;
      RD_REQ:  if (req_ready_i) state_next = RD_WAIT;
      RD_WAIT: if (rsp_valid_i) begin
        resp_next  = rsp_err_i ? RESP_SLVERR : RESP_OKAY;
        rdata_next = rsp_rdata_i;
        state_next = RD_RESP;
      end
      RD_RESP: if (s_axi_rready_i) begin
        rdata_next = '0;
        state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_reg     <= IDLE;
      aw_full_reg   <= 1'b0;
      w_full_reg    <= 1'b0;
      ar_full_reg   <= 1'b0;
      awaddr_reg    <= '0;
      wdata_reg     <= '0;
      wstrb_reg     <= '0;
      araddr_reg    <= '0;
      awready_reg   <= 1'b0;
      wready_reg    <= 1'b0;
      arready_reg   <= 1'b0;
      prefer_wr_reg <= 1'b1;
      req_write_reg <= 1'b0;
      req_addr_reg  <= '0;
      req_wdata_reg <= '0;
      req_wstrb_reg <= '0;
      resp_reg      <= '0;
      rdata_reg     <= '0;
    end else begin
      state_reg     <= state_next;
      aw_full_reg   <= aw_full_next;
      w_full_reg    <= w_full_next;
      ar_full_reg   <= ar_full_next;
      awaddr_reg    <= awaddr_next;
      wdata_reg     <= wdata_next;
      wstrb_reg     <= wstrb_next;
      araddr_reg    <= araddr_next;
      awready_reg   <= ~aw_full_next;
      wready_reg    <= ~w_full_next;
      arready_reg   <= ~ar_full_next;
      prefer_wr_reg <= prefer_wr_next;
      req_write_reg <= req_write_next;
      req_addr_reg  <= req_addr_next;
      req_wdata_reg <= req_wdata_next;
      req_wstrb_reg <= req_wstrb_next;
      resp_reg      <= resp_next;
      rdata_reg     <= rdata_next;
    end
  end

  assign s_axi_awready_o = awready_reg;
  assign s_axi_wready_o  = wready_reg;
  assign s_axi_arready_o = arready_reg;
  assign s_axi_bvalid_o  = (state_reg == WR_RESP);
  assign s_axi_bresp_o   = (state_reg == WR_RESP) ? resp_reg : 2'b00;
  assign s_axi_rvalid_o  = (state_reg == RD_RESP);
  assign s_axi_rresp_o   = (state_reg == RD_RESP) ? resp_reg : 2'b00;
  assign s_axi_rdata_o   = rdata_reg;
  assign req_valid_o     = (state_reg == WR_REQ) | (state_reg == RD_REQ);
  assign req_write_o     = req_write_reg;
  assign req_addr_o      = req_addr_reg;
  assign req_wdata_o     = req_wdata_reg;
  assign req_wstrb_o     = req_wstrb_reg;

endmodule

// File: tb/tb_komandara_axi4lite_slave.sv
// Scoreboard bench for komandara_axi4lite_slave with a small local memory target model.
module tb_komandara_axi4lite_slave;
  localparam int AW = 32;
  localparam int DW = 32;
  localparam int SW = 4;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic [AW-1:0] awaddr, araddr, req_addr;
  logic [2:0]    awprot, arprot;
  logic          awvalid, awready, wvalid, wready, bvalid, bready;
  logic          arvalid, arready, rvalid, rready;
  logic [DW-1:0] wdata, rdata, req_wdata, rsp_rdata;
  logic [SW-1:0] wstrb, req_wstrb;
  logic [1:0]    bresp, rresp;
  logic          req_valid, req_ready, req_write, rsp_valid, rsp_err;

  komandara_axi4lite_slave #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .MEM_BYTES(4096)) dut (
    .clk_i(clk), .rst_ni(rst_n),
    .s_axi_awaddr_i(awaddr), .s_axi_awprot_i(awprot), .s_axi_awvalid_i(awvalid), .s_axi_awready_o(awready),
    .s_axi_wdata_i(wdata), .s_axi_wstrb_i(wstrb), .s_axi_wvalid_i(wvalid), .s_axi_wready_o(wready),
    .s_axi_bresp_o(bresp), .s_axi_bvalid_o(bvalid), .s_axi_bready_i(bready),
    .s_axi_araddr_i(araddr), .s_axi_arprot_i(arprot), .s_axi_arvalid_i(arvalid), .s_axi_arready_o(arready),
    .s_axi_rdata_o(rdata), .s_axi_rresp_o(rresp), .s_axi_rvalid_o(rvalid), .s_axi_rready_i(rready),
    .req_valid_o(req_valid), .req_ready_i(req_ready), .req_write_o(req_write), .req_addr_o(req_addr),
    .req_wdata_o(req_wdata), .req_wstrb_o(req_wstrb),
    .rsp_valid_i(rsp_valid), .rsp_rdata_i(rsp_rdata), .rsp_err_i(rsp_err)
  );

  typedef struct { logic [31:0] addr; logic [31:0] wdata; logic [3:0] wstrb; } req_t;
  typedef struct { logic [31:0] rdata; logic [1:0] resp; } rrsp_t;

  req_t        exp_wreq_q[$];
  req_t        exp_rreq_q[$];
  logic [1:0]  exp_b_q[$];
  rrsp_t       exp_r_q[$];
  bit          req_order[$];
  logic [31:0] exp_mem [0:1023];
  logic [31:0] tgt_mem [0:1023];

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int req_cnt = 0;
  int aw_hs_cyc, ar_hs_cyc, req_first_cyc, b_first_cyc, r_first_cyc;
  bit req_prev, b_prev, r_prev;
  bit tgt_err = 0, tgt_hold = 0, tgt_rand = 0;
  bit acc_flag = 0, acc_err = 0;
  logic [31:0] acc_rdata = '0;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] d, input logic [3:0] s);
    logic [31:0] r;
    r = old;
    for (int b = 0; b < 4; b++) if (s[b]) r[8*b +: 8] = d[8*b +: 8];
    return r;
  endfunction

  initial forever begin
    @(posedge clk);
    cyc++;
  end

  // Local target: accepts requests per req_ready and answers one cycle after acceptance.
  initial begin
    req_ready = 1'b1; rsp_valid = 1'b0; rsp_err = 1'b0; rsp_rdata = '0;
    forever begin
      @(posedge clk);
      #1;
      rsp_valid = 1'b0; rsp_err = 1'b0; rsp_rdata = '0;
      if (acc_flag && !tgt_hold) begin
        rsp_valid = 1'b1; rsp_err = acc_err; rsp_rdata = acc_rdata; acc_flag = 0;
      end
      req_ready = tgt_rand ? 1'($urandom_range(0, 1)) : 1'b1;
    end
  end

  // Monitor: pops the scoreboard as the DUT produces requests and responses.
  initial forever begin
    @(negedge clk);
    if (rst_n) begin
      if (awvalid && awready) aw_hs_cyc = cyc;
      if (arvalid && arready) ar_hs_cyc = cyc;
      if (req_valid && !req_prev) req_first_cyc = cyc;
      if (bvalid && !b_prev) b_first_cyc = cyc;
      if (rvalid && !r_prev) r_first_cyc = cyc;
      req_prev = req_valid; b_prev = bvalid; r_prev = rvalid;
      if (req_valid && req_ready) begin
        req_t e;
        req_cnt++;
        req_order.push_back(req_write);
        if (req_write) begin
          if (exp_wreq_q.size() == 0) check_val("unexpected_wreq", 1, 0);
          else begin
            e = exp_wreq_q.pop_front();
            check_val("wreq_addr", req_addr, e.addr);
            check_val("wreq_wdata", req_wdata, e.wdata);
            check_val("wreq_wstrb", 32'(req_wstrb), 32'(e.wstrb));
          end
          if (!tgt_err) tgt_mem[req_addr[11:2]] = merge(tgt_mem[req_addr[11:2]], req_wdata, req_wstrb);
        end else begin
          if (exp_rreq_q.size() == 0) check_val("unexpected_rreq", 1, 0);
          else begin
            e = exp_rreq_q.pop_front();
            check_val("rreq_addr", req_addr, e.addr);
            check_val("rreq_wstrb", 32'(req_wstrb), 32'(e.wstrb));
          end
        end
        acc_rdata = tgt_mem[req_addr[11:2]];
        acc_err = tgt_err;
        if (!tgt_hold) acc_flag = 1;
      end
      if (bvalid && bready) begin
        if (exp_b_q.size() == 0) check_val("unexpected_b", 1, 0);
        else check_val("bresp", 32'(bresp), 32'(exp_b_q.pop_front()));
        $display("[%0t] B  bresp=%0d", $time, bresp);
      end
      if (rvalid && rready) begin
        rrsp_t r;
        if (exp_r_q.size() == 0) check_val("unexpected_r", 1, 0);
        else begin
          r = exp_r_q.pop_front();
          check_val("rdata", rdata, r.rdata);
          check_val("rresp", 32'(rresp), 32'(r.resp));
        end
        $display("[%0t] R  rdata=0x%08h rresp=%0d", $time, rdata, rresp);
      end
    end else begin
      req_prev = 0; b_prev = 0; r_prev = 0;
    end
  end

  task automatic drive_aw(input logic [31:0] a);
    int n = 0;
    awaddr = a; awvalid = 1'b1;
    do begin @(negedge clk); n++; end while (!awready && n < 200);
    if (!awready) check_val("aw_hs_timeout", 0, 1);
    @(posedge clk); #1; awvalid = 1'b0;
  endtask

  task automatic drive_w(input logic [31:0] d, input logic [3:0] s);
    int n = 0;
    wdata = d; wstrb = s; wvalid = 1'b1;
    do begin @(negedge clk); n++; end while (!wready && n < 200);
    if (!wready) check_val("w_hs_timeout", 0, 1);
    @(posedge clk); #1; wvalid = 1'b0;
  endtask

  task automatic drive_ar(input logic [31:0] a);
    int n = 0;
    araddr = a; arvalid = 1'b1;
    do begin @(negedge clk); n++; end while (!arready && n < 200);
    if (!arready) check_val("ar_hs_timeout", 0, 1);
    @(posedge clk); #1; arvalid = 1'b0;
  endtask

  task automatic push_write(input logic [31:0] a, input logic [31:0] d, input logic [3:0] s);
    req_t e;
    if (a < 32'd4096) begin
      e.addr = {a[31:2], 2'b00}; e.wdata = d; e.wstrb = s;
      exp_wreq_q.push_back(e);
      exp_b_q.push_back(tgt_err ? 2'b10 : 2'b00);
      if (!tgt_err) exp_mem[a[11:2]] = merge(exp_mem[a[11:2]], d, s);
    end else exp_b_q.push_back(2'b11);
  endtask

  task automatic do_write(input logic [31:0] a, input logic [31:0] d, input logic [3:0] s);
    push_write(a, d, s);
    fork
      drive_aw(a);
      drive_w(d, s);
    join
  endtask

  task automatic do_read(input logic [31:0] a);
    req_t e;
    rrsp_t r;
    if (a < 32'd4096) begin
      e.addr = {a[31:2], 2'b00}; e.wdata = '0; e.wstrb = '0;
      exp_rreq_q.push_back(e);
      r.rdata = exp_mem[a[11:2]]; r.resp = 2'b00;
    end else begin
      r.rdata = '0; r.resp = 2'b11;
    end
    exp_r_q.push_back(r);
    drive_ar(a);
  endtask

  task automatic wait_done();
    int n = 0;
    while ((exp_b_q.size() + exp_r_q.size() + exp_wreq_q.size() + exp_rreq_q.size()) != 0 && n < 500) begin
      @(posedge clk); n++;
    end
    check_val("drain_timeout", 32'(exp_b_q.size() + exp_r_q.size() + exp_wreq_q.size() + exp_rreq_q.size()), 0);
    @(posedge clk); #1;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1; rst_n = 1'b1;
    @(posedge clk); #1;
  endtask

  initial begin
    int base;
    logic [31:0] a, d;
    logic [3:0] s;
    for (int i = 0; i < 1024; i++) begin exp_mem[i] = '0; tgt_mem[i] = '0; end
    awaddr = '0; awprot = '0; awvalid = 0; wdata = '0; wstrb = '0; wvalid = 0; bready = 1;
    araddr = '0; arprot = '0; arvalid = 0; rready = 1;

    repeat (3) @(posedge clk);
    #1;
    check_val("rst_readies", {awready, wready, arready}, 3'b000);
    check_val("rst_valids", {bvalid, rvalid, req_valid}, 3'b000);
    rst_n = 1'b1;
    @(posedge clk); #1;
    check_val("post_rst_readies", {awready, wready, arready}, 3'b111);

    // Minimum-latency write and read
    do_write(32'h000, 32'hCAFEBABE, 4'hF);
    wait_done();
    check_val("wr_req_latency", 32'(req_first_cyc - aw_hs_cyc), 1);
    check_val("wr_b_latency", 32'(b_first_cyc - aw_hs_cyc), 3);
    do_read(32'h000);
    wait_done();
    check_val("rd_req_latency", 32'(req_first_cyc - ar_hs_cyc), 1);
    check_val("rd_r_latency", 32'(r_first_cyc - ar_hs_cyc), 3);
    check_val("rdata_idle_zero", rdata, 0);
    do_write(32'h002, 32'h11223344, 4'hF);
    wait_done();
    do_read(32'h000);
    wait_done();

    // W three cycles ahead of AW
    base = req_cnt;
    push_write(32'h020, 32'hA5A5_5A5A, 4'h3);
    drive_w(32'hA5A5_5A5A, 4'h3);
    repeat (3) begin
      @(negedge clk);
      check_val("w_first_wready_low", wready, 0);
      check_val("w_first_no_req", req_valid, 0);
    end
    @(posedge clk); #1;
    drive_aw(32'h020);
    wait_done();
    check_val("w_first_req_count", 32'(req_cnt - base), 1);

    // Out of window and local error
    base = req_cnt;
    do_read(32'h1000);
    wait_done();
    do_write(32'h1004, 32'hDEAD_BEEF, 4'hF);
    wait_done();
    check_val("decerr_no_req", 32'(req_cnt - base), 0);
    tgt_err = 1;
    do_write(32'h040, 32'h1234_5678, 4'hF);
    wait_done();
    tgt_err = 0;

    // Everything held valid after reset: writes and reads alternate, write first
    do_reset();
    req_order.delete();
    fork
      begin
        do_write(32'h100, 32'h0000_0100, 4'hF);
        do_write(32'h104, 32'h0000_0104, 4'hF);
      end
      begin
        do_read(32'h000);
        do_read(32'h200);
      end
    join
    wait_done();
    check_val("order_count", 32'(req_order.size()), 4);
    if (req_order.size() == 4)
      check_val("order_w_r_w_r", {req_order[0], req_order[1], req_order[2], req_order[3]}, 4'b1010);

    // B held stable under backpressure
    bready = 1'b0;
    do_write(32'h300, 32'h3333_3333, 4'hF);
    begin
      int n = 0;
      while (!bvalid && n < 100) begin @(negedge clk); n++; end
    end
    repeat (5) begin
      @(negedge clk);
      check_val("b_hold_valid", bvalid, 1);
      check_val("b_hold_resp", 32'(bresp), 0);
    end
    @(posedge clk); #1;
    bready = 1'b1;
    wait_done();

    // Random write/read-back with a stalling target
    tgt_rand = 1;
    for (int i = 0; i < 6; i++) begin
      a = 32'($urandom_range(0, 15)) << 2;
      d = $urandom;
      s = 4'($urandom_range(1, 15));
      do_write(a, d, s);
      wait_done();
      do_read(a);
      wait_done();
    end
    tgt_rand = 0;

    // Reset while waiting for the local response
    tgt_hold = 1;
    base = req_cnt;
    do_write(32'h050, 32'h5050_5050, 4'hF);
    begin
      int n = 0;
      while (req_cnt == base && n < 100) begin @(negedge clk); n++; end
      check_val("hold_req_seen", 32'(req_cnt - base), 1);
    end
    @(posedge clk); #2;
    rst_n = 1'b0;
    #1;
    check_val("async_rst_ctrl", {awready, wready, arready, bvalid, rvalid, req_valid, req_write, bresp, rresp}, 0);
    check_val("async_rst_rdata", rdata, 0);
    check_val("async_rst_req_addr", req_addr, 0);
    check_val("async_rst_req_wdata", req_wdata, 0);
    check_val("async_rst_req_wstrb", 32'(req_wstrb), 0);
    exp_b_q.delete();
    tgt_hold = 0;
    acc_flag = 0;
    repeat (2) @(posedge clk);
    #1; rst_n = 1'b1;
    @(posedge clk); #1;
    do_read(32'h000);
    wait_done();

    check_val("final_wreq_q", 32'(exp_wreq_q.size()), 0);
    check_val("final_rreq_q", 32'(exp_rreq_q.size()), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL global_timeout: got running expected finished");
    $fatal(1, "timeout");
  end
endmodule
